// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with start/pause control.
// A four-state FSM (IDLE, RUN, PAUSED, DONE) sequences the count.
// out and done are registered outputs.
// is_zero and busy are decoded directly from registers.
// AUTO_RELOAD selects single-shot (0) or periodic (1) behaviour on reaching zero.
module countdown_timer #(
   parameter int unsigned WIDTH       = 8,
   parameter bit          AUTO_RELOAD = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] out,
   output logic             is_zero,
   output logic             done,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic [WIDTH-1:0] r_reload;
   logic [WIDTH-1:0] w_reload_nxt;
   logic             r_done;
   logic             w_done_nxt;

   logic             w_count_nz;
   logic             w_count_is_one;
   logic             w_reload_nz;

   assign w_count_nz     = (r_count != CNT_ZERO);
   assign w_count_is_one = (r_count == CNT_ONE);
   assign w_reload_nz    = (r_reload != CNT_ZERO);

   // State, count, reload and done registers; reset aborts any count silently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_count  <= CNT_ZERO;
         r_reload <= CNT_ZERO;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_reload <= w_reload_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // Next-state and next-count logic; load overrides everything, then pause, then start.
   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_reload_nxt = r_reload;
      w_done_nxt   = 1'b0;

      if (load) begin
         // A load also wins over a count that would reach zero this edge.
         w_state_nxt  = ST_IDLE;
         w_count_nxt  = load_value;
         w_reload_nxt = load_value;
         w_done_nxt   = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Starting from zero would pulse done without counting; ignore it.
               if (start && w_count_nz) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end

            ST_RUN: begin
               if (pause) begin
                  w_state_nxt = ST_PAUSED;
               end else if (w_count_is_one) begin
                  w_count_nxt = CNT_ZERO;
                  w_state_nxt = ST_DONE;
                  w_done_nxt  = 1'b1;
               end else if (w_count_nz) begin
                  w_count_nxt = r_count - CNT_ONE;
                  w_state_nxt = ST_RUN;
               end else begin
                  // RUN is never entered with a zero count; recover without wrapping.
                  w_count_nxt = CNT_ZERO;
                  w_state_nxt = ST_IDLE;
               end
            end

            ST_PAUSED: begin
               // pause still high keeps the freeze even if start is also asserted.
               if (pause) begin
                  w_state_nxt = ST_PAUSED;
               end else if (start) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_PAUSED;
               end
            end

            ST_DONE: begin
               if (AUTO_RELOAD) begin
                  if (w_reload_nz) begin
                     w_count_nxt = r_reload;
                     w_state_nxt = ST_RUN;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  if (start && w_reload_nz) begin
                     w_count_nxt = r_reload;
                     w_state_nxt = ST_RUN;
                  end else begin
                     w_state_nxt = ST_DONE;
                  end
               end
            end

            default: begin
               w_state_nxt = ST_IDLE;
               w_count_nxt = CNT_ZERO;
            end
         endcase
      end
   end

   assign out     = r_count;
   assign done    = r_done;
   assign is_zero = (r_count == CNT_ZERO);
   assign busy    = (r_state == ST_RUN) || (r_state == ST_PAUSED);

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: drives a single-shot and a periodic instance with the same
// stimulus and compares both against a behavioural model of the timer rules.
module tb_countdown_timer;

   logic       clk;
   logic       reset;
   logic       load;
   logic [7:0] load_value;
   logic       start;
   logic       pause;

   logic [7:0] out0, out1;
   logic       z0, z1, d0, d1, b0, b1;

   int n_checks;
   int n_fail;

   // Behavioural model of one timer: phase 0 idle, 1 counting, 2 frozen, 3 finished.
   typedef struct {
      int cnt;
      int rel;
      int ph;
      int pulse;
   } mdl_t;

   mdl_t m [2];

   countdown_timer #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u_single (
      .clk(clk), .reset(reset), .load(load), .load_value(load_value),
      .start(start), .pause(pause),
      .out(out0), .is_zero(z0), .done(d0), .busy(b0)
   );

   countdown_timer #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u_periodic (
      .clk(clk), .reset(reset), .load(load), .load_value(load_value),
      .start(start), .pause(pause),
      .out(out1), .is_zero(z1), .done(d1), .busy(b1)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic mdl_t step(input mdl_t cur, input bit periodic,
                                 input bit ld, input int lv, input bit st, input bit pa);
      mdl_t n;
      n = cur;
      n.pulse = 0;
      if (ld) begin
         n.cnt = lv;
         n.rel = lv;
         n.ph  = 0;
      end else if (cur.ph == 0) begin
         if (st && cur.cnt > 0) n.ph = 1;
      end else if (cur.ph == 1) begin
         if (pa) begin
            n.ph = 2;
         end else begin
            n.cnt = cur.cnt - 1;
            if (n.cnt == 0) begin
               n.ph    = 3;
               n.pulse = 1;
            end
         end
      end else if (cur.ph == 2) begin
         if (!pa && st) n.ph = 1;
      end else begin
         if (periodic) begin
            if (cur.rel > 0) begin
               n.cnt = cur.rel;
               n.ph  = 1;
            end else begin
               n.ph = 0;
            end
         end else if (st && cur.rel > 0) begin
            n.cnt = cur.rel;
            n.ph  = 1;
         end
      end
      return n;
   endfunction

   task automatic compare_all();
      check("u0_out",  32'(out0), 32'(m[0].cnt));
      check("u0_done", 32'(d0),   32'(m[0].pulse));
      check("u0_busy", 32'(b0),   32'((m[0].ph == 1) || (m[0].ph == 2)));
      check("u0_zero", 32'(z0),   32'(m[0].cnt == 0));
      check("u1_out",  32'(out1), 32'(m[1].cnt));
      check("u1_done", 32'(d1),   32'(m[1].pulse));
      check("u1_busy", 32'(b1),   32'((m[1].ph == 1) || (m[1].ph == 2)));
      check("u1_zero", 32'(z1),   32'(m[1].cnt == 0));
   endtask

   // One clock: apply inputs, step the model at the edge, compare 1 unit later.
   task automatic tick(input bit ld, input int lv, input bit st, input bit pa);
      load       = ld;
      load_value = 8'(lv);
      start      = st;
      pause      = pa;
      @(posedge clk);
      for (int i = 0; i < 2; i++) m[i] = step(m[i], (i == 1), ld, lv, st, pa);
      #1;
      compare_all();
      load  = 1'b0;
      start = 1'b0;
      pause = 1'b0;
   endtask

   // Assert reset between edges, check its immediate effect, then release it.
   task automatic apply_reset();
      #2;
      reset = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         m[i].cnt = 0; m[i].rel = 0; m[i].ph = 0; m[i].pulse = 0;
      end
      compare_all();
      load = 1'b1; load_value = 8'd9; start = 1'b1;
      @(posedge clk);
      #1;
      check("rst_ignores_in", 32'(out0), 32'd0);
      check("rst_busy", 32'(b1), 32'd0);
      load = 1'b0; start = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1; load = 1'b0; load_value = 8'd0; start = 1'b0; pause = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m[i].cnt = 0; m[i].rel = 0; m[i].ph = 0; m[i].pulse = 0;
      end
      @(posedge clk);
      #1;
      apply_reset();

      // Single-shot count 3,3,2,1,0 with one done pulse.
      tick(1, 3, 0, 0); check("ss_load", 32'(out0), 32'd3);
      tick(0, 0, 1, 0); check("ss_start", 32'(out0), 32'd3); check("ss_busy", 32'(b0), 32'd1);
      tick(0, 0, 0, 0); check("ss_2", 32'(out0), 32'd2);
      tick(0, 0, 0, 0); check("ss_1", 32'(out0), 32'd1); check("ss_nodone", 32'(d0), 32'd0);
      tick(0, 0, 0, 0); check("ss_0", 32'(out0), 32'd0); check("ss_done", 32'(d0), 32'd1);
      check("ss_idle_busy", 32'(b0), 32'd0); check("ss_is_zero", 32'(z0), 32'd1);
      tick(0, 0, 0, 0); check("ss_hold", 32'(out0), 32'd0); check("ss_pulse1", 32'(d0), 32'd0);

      // Pause and resume from 3, including pause+start held while frozen.
      tick(1, 5, 0, 0);
      tick(0, 0, 1, 0);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0); check("pr_at3", 32'(out0), 32'd3);
      tick(0, 0, 0, 1); check("pr_p1", 32'(out0), 32'd3);
      tick(0, 0, 1, 1); check("pr_p2", 32'(out0), 32'd3); check("pr_busy", 32'(b0), 32'd1);
      tick(0, 0, 1, 0); check("pr_resume", 32'(out0), 32'd3);
      tick(0, 0, 0, 0); check("pr_2", 32'(out0), 32'd2);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0); check("pr_0", 32'(out0), 32'd0); check("pr_done", 32'(d0), 32'd1);

      // Periodic instance: 2,2,1,0,2,1,0 with done every third cycle.
      tick(1, 2, 0, 0); check("per_load", 32'(out1), 32'd2);
      tick(0, 0, 1, 0); check("per_start", 32'(out1), 32'd2);
      tick(0, 0, 0, 0); check("per_1", 32'(out1), 32'd1);
      tick(0, 0, 0, 0); check("per_0", 32'(out1), 32'd0); check("per_done_a", 32'(d1), 32'd1);
      tick(0, 0, 0, 0); check("per_reload", 32'(out1), 32'd2); check("per_nodone", 32'(d1), 32'd0);
      tick(0, 0, 0, 0); check("per_1b", 32'(out1), 32'd1);
      tick(0, 0, 0, 0); check("per_0b", 32'(out1), 32'd0); check("per_done_b", 32'(d1), 32'd1);

      // Load during a count.
      tick(1, 10, 0, 0);
      tick(0, 0, 1, 0);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0); check("lr_at7", 32'(out0), 32'd7);
      tick(1, 4, 0, 0); check("lr_out", 32'(out0), 32'd4); check("lr_busy", 32'(b0), 32'd0);
      check("lr_done", 32'(d0), 32'd0);

      // Load arriving on the edge where the count would reach zero.
      tick(1, 1, 0, 0);
      tick(0, 0, 1, 0);
      tick(1, 5, 0, 0); check("lz_out", 32'(out0), 32'd5); check("lz_done", 32'(d0), 32'd0);

      // Reset mid-count at 6, then a start without load is ignored.
      tick(1, 8, 0, 0);
      tick(0, 0, 1, 0);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0); check("ar_at6", 32'(out0), 32'd6);
      apply_reset();
      tick(0, 0, 1, 0); check("ar_start_ign", 32'(out0), 32'd0); check("ar_busy", 32'(b0), 32'd0);
      check("ar_nodone", 32'(d0), 32'd0);

      // Zero load: start is ignored.
      tick(1, 0, 0, 0);
      tick(0, 0, 1, 0); check("z_busy", 32'(b0), 32'd0); check("z_done", 32'(d0), 32'd0);

      // Full-scale count from 255 with no wrap.
      tick(1, 255, 0, 0);
      tick(0, 0, 1, 0); check("max_start", 32'(out0), 32'd255);
      for (int k = 0; k < 255; k++) tick(0, 0, 0, 0);
      check("max_end", 32'(out0), 32'd0); check("max_done", 32'(d0), 32'd1);
      tick(0, 0, 0, 0); check("max_nowrap", 32'(out0), 32'd0);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 399) == 0) begin
            apply_reset();
         end else begin
            tick(($urandom_range(0, 15) == 0),
                 (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12))),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock port is named clk and the reset port is named reset.
REQ-002 Parameter WIDTH, default 8, SHALL set the counter width in bits.
REQ-003 Parameter AUTO_RELOAD, default 0, SHALL select single-shot operation (0) or periodic operation (1).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 load  input  1  when high, captures load_value into the counter and into the reload register.
REQ-007 load_value  input  WIDTH  value captured on load.
REQ-008 start  input  1  starts a count from IDLE or DONE, and resumes a count from PAUSED.
REQ-009 pause  input  1  freezes the count while in RUN.
REQ-010 out  output  WIDTH  current count, registered.
REQ-011 is_zero  output  1  combinational indication that out == 0.
REQ-012 done  output  1  registered one-cycle pulse when the count reaches 0.
REQ-013 busy  output  1  high in the RUN and PAUSED states.

Function
REQ-014 The state machine SHALL have four states: IDLE, RUN, PAUSED and DONE; all transitions occur on the rising edge of clk.
REQ-015 Input priority SHALL be load, then pause, then start.
REQ-016 load high in any state SHALL produce, at the next edge, out = load_value, reload = load_value, state IDLE and done = 0.
REQ-017 IDLE with start high and out != 0 SHALL move to RUN with no decrement on that edge; if out == 0, start SHALL be ignored and the state remains IDLE.
REQ-018 RUN with pause low SHALL apply out <= out - 1 at every edge.
REQ-019 In RUN, the edge at which out goes from 1 to 0 SHALL enter DONE and set done = 1 for exactly that one following cycle.
REQ-020 RUN with pause high SHALL move to PAUSED, holding out with no decrement on that edge.
REQ-021 PAUSED SHALL hold out while start is low; start high SHALL return the block to RUN with no decrement on that edge, and decrementing resumes on the next edge.
REQ-022 DONE with AUTO_RELOAD = 0 SHALL hold out = 0 until load or start.
REQ-023 In DONE with AUTO_RELOAD = 0, start with reload != 0 SHALL set out <= reload and move to RUN; start with reload == 0 SHALL be ignored.
REQ-024 DONE with AUTO_RELOAD = 1 SHALL, one edge after entry, set out <= reload and move to RUN if reload != 0, or move to IDLE if reload == 0; start and pause are not required in DONE for this reload.
REQ-025 The counter SHALL never decrement from 0: there is no underflow or wrap-around.
REQ-026 The maximum load value SHALL be 2^WIDTH - 1 and SHALL count down fully to 0.
REQ-027 A load in the same cycle as the count reaching 0 SHALL win: done = 0 and out = load_value.
REQ-028 pause and start both high in RUN SHALL result in PAUSED.
REQ-029 pause and start both high in PAUSED SHALL keep the block in PAUSED.
REQ-030 is_zero SHALL be derived combinationally from the registered out; busy SHALL be decoded from the state register.

Reset
REQ-031 When reset is low, the block SHALL immediately and asynchronously force out = 0, reload = 0, state IDLE, done = 0 and busy = 0, so that is_zero = 1.
REQ-032 While reset is low, all inputs SHALL be ignored.
REQ-033 After reset is deasserted, the first active edge SHALL operate normally.
REQ-034 Reset asserted mid-count SHALL abort the count with no done pulse.

Verification
REQ-035 Single-shot count: load = 1 with load_value = 3, then start -> out = 3,3,2,1,0 on successive cycles; done = 1 only in the cycle out first equals 0; busy drops at DONE; is_zero = 1.
REQ-036 Pause and resume: load 5, start, run until out = 3, pause for 2 cycles, then start -> out holds at 3 for the paused cycles plus the resume cycle, then continues 2,1,0 with a single done pulse.
REQ-037 Periodic count: AUTO_RELOAD = 1, load 2, start -> out = 2,2,1,0,2,1,0,...; done pulses every 3 cycles.
REQ-038 Load during RUN: load 10, start, then load 4 while out = 7 -> next out = 4, state IDLE, busy = 0, no done pulse.
REQ-039 Asynchronous reset: reset driven low between clock edges while out = 6 in RUN -> out = 0 and busy = 0 before the next edge; a subsequent start with no load is ignored.
REQ-040 Boundary values: load 0 then start -> remains IDLE with no done pulse; WIDTH = 8 with load 255 -> exactly 255 decrements to 0 and no wrap to 255.
